// File: rtl/pool_pkg.sv
// Shared definitions for the 2x2 pooling pipeline: default geometry, sample
// types and the pixel-position classifier used by the window generator.
package pool_pkg;

    localparam int unsigned PIX_W     = 4;
    localparam int unsigned N_DEFAULT = 180;
    localparam int unsigned CHANNELS  = 3;
    localparam int unsigned CHAN_W    = $clog2(CHANNELS);

    typedef logic [PIX_W-1:0] pix_t;

    typedef struct packed {
        pix_t tl;
        pix_t tr;
        pix_t bl;
        pix_t br;
    } win_t;

    // Role of an incoming pixel inside its 2x2 block
    typedef enum logic [1:0] {
        POS_EVEN_ROW  = 2'd0,  // top row: goes to the line buffer
        POS_ODD_LEFT  = 2'd1,  // bottom-left: parked in the hold register
        POS_ODD_RIGHT = 2'd2   // bottom-right: completes a window
    } pos_e;

    function automatic pos_e classify_pos(input logic row_odd, input logic col_odd);
        if (!row_odd) begin
            return POS_EVEN_ROW;
        end
        if (!col_odd) begin
            return POS_ODD_LEFT;
        end
        return POS_ODD_RIGHT;
    endfunction

endpackage

// File: rtl/pool_line_buf.sv
// Single-row line buffer: one synchronous write port and two combinational
// read ports, used to recall the top row of each 2x2 block.
module pool_line_buf #(
    parameter int unsigned N     = 180,
    parameter int unsigned PIX_W = 4,
    parameter int unsigned AW    = $clog2(N)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [PIX_W-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_a_i,
    input  logic [AW-1:0]    raddr_b_i,
    output logic [PIX_W-1:0] rdata_a_o,
    output logic [PIX_W-1:0] rdata_b_o
);

    logic [PIX_W-1:0] mem_q [N];

    // Store the even-row sample; contents are never cleared
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = mem_q[raddr_a_i];
    assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/pool_window_gen.sv
// Assembles non-overlapping 2x2 windows from a raster-ordered, channel-planar
// pixel stream and presents them on a valid/ready output register.
module pool_window_gen #(
    parameter int unsigned N        = pool_pkg::N_DEFAULT,
    parameter int unsigned PIX_W    = pool_pkg::PIX_W,
    parameter int unsigned CHANNELS = pool_pkg::CHANNELS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PIX_W-1:0] pix_in,
    input  logic             pix_valid,
    output logic             pix_ready,
    output logic [PIX_W-1:0] win_in1,
    output logic [PIX_W-1:0] win_in2,
    output logic [PIX_W-1:0] win_in3,
    output logic [PIX_W-1:0] win_in4,
    output logic [1:0]       win_chan,
    output logic             win_last,
    output logic             win_valid,
    input  logic             win_ready
);

    import pool_pkg::*;

    localparam int unsigned AW = $clog2(N);

    logic [AW-1:0]    col_q, col_d;
    logic [AW-1:0]    row_q, row_d;
    logic [1:0]       chan_q, chan_d;
    logic [PIX_W-1:0] hold_q;
    logic [PIX_W-1:0] win_tl_q, win_tr_q, win_bl_q, win_br_q;
    logic [1:0]       win_chan_q;
    logic             win_last_q;
    logic             win_valid_q;

    logic             accept;
    logic             col_last, row_last, chan_last;
    pos_e             pos;
    logic             lb_we;
    logic             produce;
    logic [PIX_W-1:0] lb_left, lb_right;

    assign pix_ready = !win_valid_q || win_ready;
    assign accept    = pix_valid && pix_ready;

    assign col_last  = (col_q == AW'(N - 1));
    assign row_last  = (row_q == AW'(N - 1));
    assign chan_last = (chan_q == 2'(CHANNELS - 1));

    assign pos     = classify_pos(row_q[0], col_q[0]);
    assign lb_we   = accept && (pos == POS_EVEN_ROW);
    assign produce = accept && (pos == POS_ODD_RIGHT);

    pool_line_buf #(
        .N     (N),
        .PIX_W (PIX_W),
        .AW    (AW)
    ) u_line_buf (
        .clk       (clk),
        .we_i      (lb_we),
        .waddr_i   (col_q),
        .wdata_i   (pix_in),
        .raddr_a_i (col_q - 1'b1),
        .raddr_b_i (col_q),
        .rdata_a_o (lb_left),
        .rdata_b_o (lb_right)
    );

    // Raster position (col, row, plane) advance on each accepted pixel
    always_comb begin
        col_d  = col_q;
        row_d  = row_q;
        chan_d = chan_q;
        if (accept) begin
            if (col_last) begin
                col_d = '0;
                if (row_last) begin
                    row_d  = '0;
                    chan_d = chan_last ? '0 : chan_q + 2'd1;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // Position counters, bottom-left hold and output window register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_q       <= '0;
            row_q       <= '0;
            chan_q      <= '0;
            hold_q      <= '0;
            win_tl_q    <= '0;
            win_tr_q    <= '0;
            win_bl_q    <= '0;
            win_br_q    <= '0;
            win_chan_q  <= '0;
            win_last_q  <= 1'b0;
            win_valid_q <= 1'b0;
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            chan_q <= chan_d;
            if (accept && (pos == POS_ODD_LEFT)) begin
                hold_q <= pix_in;
            end
            // A new window may replace one being consumed this same cycle
            if (produce) begin
                win_tl_q    <= lb_left;
                win_tr_q    <= lb_right;
                win_bl_q    <= hold_q;
                win_br_q    <= pix_in;
                win_chan_q  <= chan_q;
                win_last_q  <= chan_last && row_last && col_last;
                win_valid_q <= 1'b1;
            end else if (win_ready) begin
                win_valid_q <= 1'b0;
            end
        end
    end

    assign win_in1   = win_tl_q;
    assign win_in2   = win_tr_q;
    assign win_in3   = win_bl_q;
    assign win_in4   = win_br_q;
    assign win_chan  = win_chan_q;
    assign win_last  = win_last_q;
    assign win_valid = win_valid_q;

endmodule

// File: tb/tb_pool_window_gen.sv
// Bench for pool_window_gen (N=4, 3 planes): whole frames are built as
// arrays, the expected window list is cut from them in 2x2 blocks, and a
// cycle-level model of the output register is compared every cycle.
module tb_pool_window_gen;

    localparam int unsigned N = 4;
    localparam int unsigned C = 3;
    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] pix_in;
    logic         pix_valid;
    logic         pix_ready;
    logic [W-1:0] win_in1, win_in2, win_in3, win_in4;
    logic [1:0]   win_chan;
    logic         win_last;
    logic         win_valid;
    logic         win_ready;

    always #5 clk = ~clk;

    pool_window_gen #(
        .N        (N),
        .PIX_W    (W),
        .CHANNELS (C)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pix_in    (pix_in),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .win_in1   (win_in1),
        .win_in2   (win_in2),
        .win_in3   (win_in3),
        .win_in4   (win_in4),
        .win_chan  (win_chan),
        .win_last  (win_last),
        .win_valid (win_valid),
        .win_ready (win_ready)
    );

    typedef struct {
        logic [W-1:0] tl, tr, bl, br;
        logic [1:0]   ch;
        logic         last;
    } exp_t;

    exp_t         exp_q[$];
    logic [W-1:0] pix_q[$];
    int           checks = 0;
    int           errors = 0;
    int unsigned  sent_idx = 0;
    int unsigned  consumed = 0;
    logic         mvalid = 1'b0;
    exp_t         mwin;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Build one full frame (all planes) and its expected windows
    task automatic add_frame(input bit rnd);
        logic [W-1:0] img [C][N][N];
        exp_t e;
        for (int unsigned c = 0; c < C; c++)
            for (int unsigned r = 0; r < N; r++)
                for (int unsigned k = 0; k < N; k++) begin
                    img[c][r][k] = rnd ? W'($urandom) : W'((c * 5 + r * N + k) % 16);
                    pix_q.push_back(img[c][r][k]);
                end
        for (int unsigned c = 0; c < C; c++)
            for (int unsigned i = 0; i < N / 2; i++)
                for (int unsigned j = 0; j < N / 2; j++) begin
                    e.tl   = img[c][2*i][2*j];
                    e.tr   = img[c][2*i][2*j+1];
                    e.bl   = img[c][2*i+1][2*j];
                    e.br   = img[c][2*i+1][2*j+1];
                    e.ch   = 2'(c);
                    e.last = (c == C - 1) && (i == N / 2 - 1) && (j == N / 2 - 1);
                    exp_q.push_back(e);
                end
    endtask

    // One clock: drive at negedge, compare against the model, advance the model
    task automatic cycle(input bit v, input bit rdy);
        bit          acc;
        int unsigned idx, r, k;
        @(negedge clk);
        pix_valid = v && (pix_q.size() > 0);
        pix_in    = pix_valid ? pix_q[0] : W'($urandom);
        win_ready = rdy;
        #1;
        chk("pix_ready", 32'(pix_ready), 32'(!mvalid || rdy));
        chk("win_valid", 32'(win_valid), 32'(mvalid));
        if (mvalid) begin
            chk("win_in1", 32'(win_in1), 32'(mwin.tl));
            chk("win_in2", 32'(win_in2), 32'(mwin.tr));
            chk("win_in3", 32'(win_in3), 32'(mwin.bl));
            chk("win_in4", 32'(win_in4), 32'(mwin.br));
            chk("win_chan", 32'(win_chan), 32'(mwin.ch));
            chk("win_last", 32'(win_last), 32'(mwin.last));
        end
        acc = pix_valid && (!mvalid || rdy);
        @(posedge clk);
        if (mvalid && rdy) consumed++;
        if (acc) begin
            idx = sent_idx % (N * N);
            r   = idx / N;
            k   = idx % N;
            void'(pix_q.pop_front());
            sent_idx++;
            if ((r % 2 == 1) && (k % 2 == 1)) begin
                if (exp_q.size() == 0) begin
                    chk("exp_underflow", 32'(exp_q.size()), 32'd1);
                    mvalid = 1'b0;
                end else begin
                    mwin   = exp_q.pop_front();
                    mvalid = 1'b1;
                end
            end else if (mvalid && rdy) begin
                mvalid = 1'b0;
            end
        end else if (mvalid && rdy) begin
            mvalid = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        pix_valid = 1'b0;
        win_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        mvalid   = 1'b0;
        sent_idx = 0;
        pix_q.delete();
        exp_q.delete();
    endtask

    // Run until every queued pixel has been windowed and consumed
    task automatic drain(input int unsigned vgap, input int unsigned rgap, input int unsigned budget);
        int unsigned n = 0;
        while ((pix_q.size() > 0 || mvalid) && n < budget) begin
            cycle($urandom_range(99, 0) >= vgap, $urandom_range(99, 0) >= rgap);
            n++;
        end
        chk("drain_timeout", 32'(n < budget), 32'd1);
        chk("exp_leftover", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        pix_valid = 1'b0;
        pix_in    = '0;
        win_ready = 1'b0;
        mwin      = '{default: '0};
        repeat (2) @(posedge clk);
        do_reset();

        #1;
        chk("rst_valid", 32'(win_valid), 32'd0);
        chk("rst_in1", 32'(win_in1), 32'd0);
        chk("rst_in2", 32'(win_in2), 32'd0);
        chk("rst_in3", 32'(win_in3), 32'd0);
        chk("rst_in4", 32'(win_in4), 32'd0);
        chk("rst_chan", 32'(win_chan), 32'd0);
        chk("rst_last", 32'(win_last), 32'd0);

        // Pattern frames back to back; hold off the first window for 10 cycles
        add_frame(1'b0);
        add_frame(1'b0);
        consumed = 0;
        for (int n = 0; n < 20 && !mvalid; n++) cycle(1'b1, 1'b1);
        chk("first_win_tl", 32'(mwin.tl), 32'd0);
        repeat (10) cycle(1'b1, 1'b0);
        drain(0, 0, 200);
        chk("win_count", 32'(consumed), 32'(2 * C * (N / 2) * (N / 2)));

        // Reset in the middle of row 3 of plane 1, then a fresh frame
        add_frame(1'b0);
        for (int n = 0; n < 100 && sent_idx < N * N + 3 * N + 2; n++) cycle(1'b1, 1'b1);
        do_reset();
        cycle(1'b0, 1'b1);
        add_frame(1'b0);
        drain(0, 0, 200);

        // Random images with random input and output gaps
        add_frame(1'b1);
        add_frame(1'b1);
        add_frame(1'b1);
        add_frame(1'b1);
        drain(30, 30, 2000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
